sw_debounce: RTL and testbench



---
 rtl/lsu_io_pkg.sv | 7 +
 rtl/sw_debounce_cell.sv | 64 ++++++
 rtl/sw_debounce.sv | 55 +++++
 tb/tb_sw_debounce.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lsu_io_pkg.sv
// Shared defaults and types for the LSU input-peripheral path.
package lsu_io_pkg;
  localparam int NUM_SW_DEFAULT          = 17;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef logic [NUM_SW_DEFAULT-1:0] sw_vec_t;
endpackage

// File: rtl/sw_debounce_cell.sv
// One switch bit: two-flop synchroniser, stability counter, stable flop
// and registered rise/fall pulses.
module sw_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = lsu_io_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    sync1_d  = i_raw;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Any sample agreeing with the stable value restarts the run from zero.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign o_stable = stable_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;
endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches for the LSU i_io_sw bus.
// Optional sticky change flags are built when SW_DEBOUNCE_STICKY_EN is defined.
module sw_debounce
  import lsu_io_pkg::*;
#(
  parameter int NUM_SW          = NUM_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_SW-1:0] i_sw_raw,
  input  logic              i_clr_chg,
  output logic [NUM_SW-1:0] o_io_sw,
  output logic [NUM_SW-1:0] o_sw_rise,
  output logic [NUM_SW-1:0] o_sw_fall,
  output logic              o_any_edge,
  output logic [NUM_SW-1:0] o_sw_changed
);
  for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
    sw_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_raw   (i_sw_raw[i]),
      .o_stable(o_io_sw[i]),
      .o_rise  (o_sw_rise[i]),
      .o_fall  (o_sw_fall[i])
    );
  end

  assign o_any_edge = |(o_sw_rise | o_sw_fall);

`ifdef SW_DEBOUNCE_STICKY_EN
  logic [NUM_SW-1:0] chg_q, chg_d;

  // Events are ORed in after the clear so a coincident edge is never lost.
  always_comb begin
    chg_d = chg_q;
    if (i_clr_chg) chg_d = '0;
    chg_d = chg_d | o_sw_rise | o_sw_fall;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) chg_q <= '0;
    else       chg_q <= chg_d;
  end

  assign o_sw_changed = chg_q;
`else
  logic unused_clr_chg;
  assign unused_clr_chg = i_clr_chg;
  assign o_sw_changed   = '0;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, NUM_SW=17.
module tb_sw_debounce;
  localparam int NSW = 17;
  localparam int DC  = 4;
`ifdef SW_DEBOUNCE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] sw_raw;
  logic           clr_chg;
  logic [NSW-1:0] io_sw, sw_rise, sw_fall, sw_changed;
  logic           any_edge;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .NUM_SW         (NSW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .i_sw_raw    (sw_raw),
    .i_clr_chg   (clr_chg),
    .o_io_sw     (io_sw),
    .o_sw_rise   (sw_rise),
    .o_sw_fall   (sw_fall),
    .o_any_edge  (any_edge),
    .o_sw_changed(sw_changed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [NSW-1:0] v);
    sw_raw = v;
    repeat (8) tick();
  endtask

  task automatic check_quiet(input string tag, input logic [NSW-1:0] exp_io);
    check({tag, "_io"},   32'(io_sw),    32'(exp_io));
    check({tag, "_rise"}, 32'(sw_rise),  32'h0);
    check({tag, "_fall"}, 32'(sw_fall),  32'h0);
    check({tag, "_any"},  32'(any_edge), 32'h0);
  endtask

  logic [8:0] bounce;

  initial begin
    rst     = 1'b1;
    sw_raw  = 17'h1FFFF;
    clr_chg = 1'b0;

    // Reset held three edges with all raw switches high
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("rst", 17'h0);
      check("rst_chg", 32'(sw_changed), 32'h0);
    end
    rst = 1'b0;
    tick();
    check_quiet("rst_rel", 17'h0);
    check("rst_rel_chg", 32'(sw_changed), 32'h0);
    // Release edge loaded sync1; commit lands five edges after it
    for (int i = 1; i < 6; i++) begin
      tick();
      check("rst_commit_io", 32'(io_sw), (i == 5) ? 32'h1FFFF : 32'h0);
      check("rst_commit_rise", 32'(sw_rise), (i == 5) ? 32'h1FFFF : 32'h0);
    end
    settle(17'h0);
    check_quiet("settle0", 17'h0);

    // Clean rise on bit0
    sw_raw = 17'h00001;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("clean_io",   32'(io_sw),    (i >= 5) ? 32'h1 : 32'h0);
      check("clean_rise", 32'(sw_rise),  (i == 5) ? 32'h1 : 32'h0);
      check("clean_any",  32'(any_edge), (i == 5) ? 32'h1 : 32'h0);
      check("clean_fall", 32'(sw_fall),  32'h0);
    end
    settle(17'h0);

    // Bounce on bit3: 1,0,1,1,0,1,1,1,1 then held high; commit at edge 10
    bounce = 9'b111101101;
    for (int i = 0; i < 12; i++) begin
      sw_raw = (i < 9) ? 17'(bounce[i]) << 3 : 17'h00008;
      tick();
      check("bounce_io",   32'(io_sw),   (i >= 10) ? 32'h8 : 32'h0);
      check("bounce_rise", 32'(sw_rise), (i == 10) ? 32'h8 : 32'h0);
    end
    settle(17'h0);

    // Multi-bit rise then fall
    sw_raw = 17'h10005;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("multi_rise", 32'(sw_rise),  (i == 5) ? 32'h10005 : 32'h0);
      check("multi_any",  32'(any_edge), (i == 5) ? 32'h1 : 32'h0);
    end
    check("multi_io_hi", 32'(io_sw), 32'h10005);
    sw_raw = 17'h0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("multi_fall", 32'(sw_fall),  (i == 5) ? 32'h10005 : 32'h0);
      check("multi_io",   32'(io_sw),    (i >= 5) ? 32'h0 : 32'h10005);
      check("multi_anyf", 32'(any_edge), (i == 5) ? 32'h1 : 32'h0);
    end
    settle(17'h0);

    // Reset mid-count on bit5
    sw_raw = 17'h00020;
    tick();
    tick();
    check("midrst_pre", 32'(io_sw), 32'h0);
    rst = 1'b1;
    tick();
    check_quiet("midrst_in", 17'h0);
    rst = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      check("midrst_io",   32'(io_sw),   (j >= 5) ? 32'h20 : 32'h0);
      check("midrst_rise", 32'(sw_rise), (j == 5) ? 32'h20 : 32'h0);
    end
    settle(17'h0);

    // Sticky change flags
    clr_chg = 1'b1;
    tick();
    clr_chg = 1'b0;
    check("sticky_clr0", 32'(sw_changed), 32'h0);
    sw_raw = 17'h00004;
    for (int i = 0; i < 6; i++) tick();
    check("sticky_rise", 32'(sw_rise), 32'h4);
    tick();
    check("sticky_set", 32'(sw_changed), STICKY ? 32'h4 : 32'h0);
    sw_raw = 17'h0;
    for (int i = 0; i < 6; i++) tick();
    check("sticky_fall", 32'(sw_fall), 32'h4);
    clr_chg = 1'b1;
    tick();
    clr_chg = 1'b0;
    check("sticky_coinc", 32'(sw_changed), STICKY ? 32'h4 : 32'h0);
    tick();
    check("sticky_hold", 32'(sw_changed), STICKY ? 32'h4 : 32'h0);
    clr_chg = 1'b1;
    tick();
    clr_chg = 1'b0;
    check("sticky_clr", 32'(sw_changed), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
